// File: rtl/fifo_serial_tx_if.sv
// FIFO read-side and serial-line bundle for the fifo_serial_tx drain stage.
// The master modport is the transmitter; the slave modport is the FIFO and line observer.
interface fifo_serial_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_read;
    logic                  tx;
    logic                  busy;
    logic                  done;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and shifts each out as an async serial frame:
// one start bit, DATA_WIDTH data bits LSB first, one stop bit. Frames run back-to-back while data is queued.
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    fifo_serial_tx_if.master bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         clk_cnt_q;
    logic [BW-1:0]         bit_idx_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  at_end_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    assign at_end_s  = (clk_cnt_q == CNT_LAST);
    assign shifted_s = shreg_q >> 1;
    // A pop is only legal from IDLE or on the final stop-bit cycle, so back-to-back frames carry no idle bit.
    assign pop_s     = !reset && !bus.fifo_empty &&
                       ((state_q == IDLE) || ((state_q == STOP) && at_end_s));

    assign bus.fifo_read = pop_s;
    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Frame sequencer: state, bit timing, shift register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (pop_s) begin
            shreg_q   <= bus.fifo_data;
            state_q   <= START;
            clk_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= (state_q == STOP);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                end
                START: begin
                    if (at_end_s) begin
                        state_q   <= DATA;
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (at_end_s) begin
                        clk_cnt_q <= '0;
                        shreg_q   <= shifted_s;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + BW'(1);
                            tx_q      <= shifted_s[0];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (at_end_s) begin
                        state_q   <= IDLE;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: a small show-ahead FIFO model feeds the DUT and each frame is decoded from tx.
module tb_fifo_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fifo_serial_tx_if #(.DATA_WIDTH(DW)) bus ();

    fifo_serial_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Show-ahead FIFO model: head word valid whenever non-empty, popped on an edge with fifo_read high.
    logic [DW-1:0] mem [0:63];
    logic [5:0]    wr_ptr = 6'd0;
    logic [5:0]    rd_ptr = 6'd0;
    logic          full_s;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_data  = mem[rd_ptr];
    assign full_s         = ((wr_ptr - rd_ptr) == 6'd16);

    int rd_count    = 0;
    int done_count  = 0;
    int uflow_count = 0;
    int checks      = 0;
    int failures    = 0;

    always @(posedge clk) begin
        if (bus.fifo_read) begin
            if (bus.fifo_empty) uflow_count <= uflow_count + 1;
            else                rd_ptr      <= rd_ptr + 6'd1;
            rd_count <= rd_count + 1;
        end
        if (bus.done) done_count <= done_count + 1;
    end

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    // Samples one full frame, starting at the negedge after the pop edge; ends on the last stop-bit negedge.
    task automatic check_frame(input logic [DW-1:0] d, input string name);
        logic [DW+1:0] exp_bits;
        logic [DW+1:0] got_bits;
        logic          stable;
        exp_bits = {1'b1, d, 1'b0};
        got_bits = '0;
        stable   = 1'b1;
        for (int b = 0; b < DW + 2; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0) got_bits[b] = bus.tx;
                else if (bus.tx !== got_bits[b]) stable = 1'b0;
            end
        end
        checks++;
        if (got_bits !== exp_bits || stable !== 1'b1) begin
            failures++;
            $display("FAIL %s: frame bits(stop..start)=%b stable=%0d, required %b stable=1",
                     name, got_bits, stable, exp_bits);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.tx, bus.busy, bus.done, bus.fifo_read} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state: tx,busy,done,read=%b required 1000",
                     {bus.tx, bus.busy, bus.done, bus.fifo_read});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle: tx,busy,done=%b required 100", {bus.tx, bus.busy, bus.done});
        end
    endtask

    task automatic test_single_word();
        int r0, d0;
        r0 = rd_count;
        d0 = done_count;
        @(negedge clk);
        push(8'hA5);
        #1;
        checks++;
        if (bus.fifo_read !== 1'b1) begin
            failures++;
            $display("FAIL single_pop_latency: fifo_read=%b required 1", bus.fifo_read);
        end
        check_frame(8'hA5, "single_frame_A5");
        checks++;
        if ({bus.busy, bus.done, bus.fifo_read} !== 3'b100) begin
            failures++;
            $display("FAIL single_last_stop_cycle: busy,done,read=%b required 100",
                     {bus.busy, bus.done, bus.fifo_read});
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.fifo_empty, bus.tx} !== 4'b0111) begin
            failures++;
            $display("FAIL single_done: busy,done,empty,tx=%b required 0111",
                     {bus.busy, bus.done, bus.fifo_empty, bus.tx});
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || (rd_count - r0) != 1 || (done_count - d0) != 1) begin
            failures++;
            $display("FAIL single_counts: done=%b reads=%0d dones=%0d required 0/1/1",
                     bus.done, rd_count - r0, done_count - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [0:2];
        int r0, d0;
        vals[0] = 8'h01;
        vals[1] = 8'hFF;
        vals[2] = 8'h3C;
        r0 = rd_count;
        d0 = done_count;
        @(negedge clk);
        for (int i = 0; i < 3; i++) push(vals[i]);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_frame(vals[i], $sformatf("b2b_frame%0d", i));
            checks++;
            if (bus.fifo_read !== (i < 2 ? 1'b1 : 1'b0) || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_read_spacing%0d: read=%b busy=%b required read=%0d busy=1",
                         i, bus.fifo_read, bus.busy, (i < 2) ? 1 : 0);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ((rd_count - r0) != 3 || (done_count - d0) != 3) begin
            failures++;
            $display("FAIL b2b_counts: reads=%0d dones=%0d required 3/3", rd_count - r0, done_count - d0);
        end
    endtask

    task automatic test_idle_empty();
        int bad, r0;
        bad = 0;
        r0  = rd_count;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({bus.fifo_read, bus.tx, bus.busy} !== 3'b010) bad++;
        end
        checks++;
        if (bad != 0 || rd_count != r0) begin
            failures++;
            $display("FAIL idle_empty: bad_cycles=%0d reads=%0d required 0/0", bad, rd_count - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0, d0, bad;
        r0  = rd_count;
        d0  = done_count;
        bad = 0;
        @(negedge clk);
        push(8'h5A);
        push(8'h77);
        repeat (18) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_bit3: tx=%b busy=%b required 1/1", bus.tx, bus.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.tx, bus.busy, bus.done, bus.fifo_read} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_reset_abort: tx,busy,done,read=%b required 1000",
                     {bus.tx, bus.busy, bus.done, bus.fifo_read});
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.fifo_read !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || done_count != d0) begin
            failures++;
            $display("FAIL mid_reset_hold: bad_cycles=%0d dones=%0d required 0/0", bad, done_count - d0);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.fifo_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_resume: fifo_read=%b required 1", bus.fifo_read);
        end
        check_frame(8'h77, "mid_reset_next_word");
        repeat (2) @(negedge clk);
        checks++;
        if ((rd_count - r0) != 2 || (done_count - d0) != 1 || bus.fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_counts: reads=%0d dones=%0d empty=%b required 2/1/1",
                     rd_count - r0, done_count - d0, bus.fifo_empty);
        end
    endtask

    task automatic test_full_drain();
        int r0, d0;
        r0 = rd_count;
        d0 = done_count;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push(DW'(i));
        #1;
        checks++;
        if (full_s !== 1'b1 || bus.fifo_read !== 1'b1) begin
            failures++;
            $display("FAIL drain_full: full=%b read=%b required 1/1", full_s, bus.fifo_read);
        end
        for (int i = 0; i < 16; i++) begin
            check_frame(DW'(i), $sformatf("drain_frame%0d", i));
            if (i == 0) begin
                checks++;
                if (full_s !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_full_drop: full=%b required 0", full_s);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ((rd_count - r0) != 16 || (done_count - d0) != 16 || bus.fifo_empty !== 1'b1 || uflow_count != 0) begin
            failures++;
            $display("FAIL drain_counts: reads=%0d dones=%0d empty=%b underflows=%0d required 16/16/1/0",
                     rd_count - r0, done_count - d0, bus.fifo_empty, uflow_count);
        end
    endtask

    task automatic test_concurrent_write();
        int r0, d0;
        r0 = rd_count;
        d0 = done_count;
        @(negedge clk);
        push(8'hC3);
        check_frame(8'hC3, "concurrent_first");
        push(8'h96);
        #1;
        if (bus.fifo_read !== 1'b1) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.fifo_read !== 1'b1) begin
                failures++;
                $display("FAIL concurrent_pop: fifo_read=%b required 1", bus.fifo_read);
            end
        end
        check_frame(8'h96, "concurrent_second");
        repeat (2) @(negedge clk);
        checks++;
        if ((rd_count - r0) != 2 || (done_count - d0) != 2 || bus.fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL concurrent_counts: reads=%0d dones=%0d empty=%b required 2/2/1",
                     rd_count - r0, done_count - d0, bus.fifo_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_idle_empty();
        test_reset_mid_frame();
        test_full_drain();
        test_concurrent_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
